// File: rtl/mips_pipe_pkg.sv
// Shared pipeline definitions: forwarding select codes, the zero register and
// the per-stage destination tag.
package mips_pipe_pkg;

  localparam int unsigned REG_W = 5;

  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_MEM = 2'd1;
  localparam logic [1:0] FWD_WB  = 2'd2;

  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [REG_W-1:0] dst;
    logic             reg_write;
    logic             mem_read;
  } tag_t;

endpackage

// File: rtl/fwd_select.sv
// Operand-forwarding select for one source register: the youngest in-flight
// producer wins, and $0 never forwards.
module fwd_select
  import mips_pipe_pkg::*;
(
  input  logic [REG_W-1:0] src_i,
  input  logic [REG_W-1:0] ex_dst_i,
  input  logic             ex_wr_i,
  input  logic [REG_W-1:0] mem_dst_i,
  input  logic             mem_wr_i,
  output logic [1:0]       sel_c
);

  always_comb begin
    sel_c = FWD_RF;
    if (src_i != REG_ZERO) begin
      if (ex_wr_i && (ex_dst_i == src_i)) begin
        sel_c = FWD_MEM;
      end else if (mem_wr_i && (mem_dst_i == src_i)) begin
        sel_c = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and load-use hazard control for the 5-stage pipeline: tracks
// destination tags in EX/MEM, registers EX operand selects, stalls on load-use.
module fwd_hazard_ctrl
  import mips_pipe_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic [REG_ADDR_W-1:0] id_dst,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  flush,
  output logic [1:0]            fwd_a,
  output logic [1:0]            fwd_b,
  output logic                  stall,
  output logic [CNT_W-1:0]      stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // The WB tag has no consumer: the register file writes before it reads,
  // so only the EX and MEM tags are held.
  tag_t             ex_q, ex_d;
  logic [REG_W-1:0] mem_dst_q;
  logic             mem_wr_q;
  logic [1:0]       fwd_a_q, fwd_a_d;
  logic [1:0]       fwd_b_q, fwd_b_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [REG_W-1:0] rs_c, rt_c, dst_c;
  logic [1:0]       sel_a_c, sel_b_c;
  logic             stall_c, enter_c;

  assign rs_c  = REG_W'(id_rs);
  assign rt_c  = REG_W'(id_rt);
  assign dst_c = REG_W'(id_dst);

  fwd_select u_sel_a (
    .src_i     (rs_c),
    .ex_dst_i  (ex_q.dst),
    .ex_wr_i   (ex_q.reg_write),
    .mem_dst_i (mem_dst_q),
    .mem_wr_i  (mem_wr_q),
    .sel_c     (sel_a_c)
  );

  fwd_select u_sel_b (
    .src_i     (rt_c),
    .ex_dst_i  (ex_q.dst),
    .ex_wr_i   (ex_q.reg_write),
    .mem_dst_i (mem_dst_q),
    .mem_wr_i  (mem_wr_q),
    .sel_c     (sel_b_c)
  );

  // Load in EX feeding the ID instruction; flush suppresses it.
  always_comb begin
    stall_c = id_valid && !flush && ex_q.mem_read && ex_q.reg_write &&
              (ex_q.dst != REG_ZERO) &&
              ((ex_q.dst == rs_c) || (ex_q.dst == rt_c));
    enter_c = id_valid && !stall_c && !flush;
  end

  // Next state: EX entry or bubble, selects for the entering instruction.
  always_comb begin
    ex_d    = '0;
    fwd_a_d = FWD_RF;
    fwd_b_d = FWD_RF;
    cnt_d   = cnt_q;
    if (enter_c) begin
      ex_d.dst       = dst_c;
      ex_d.reg_write = id_reg_write;
      ex_d.mem_read  = id_mem_read;
      fwd_a_d        = sel_a_c;
      fwd_b_d        = sel_b_c;
    end
    if (stall_c && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q      <= '0;
      mem_dst_q <= REG_ZERO;
      mem_wr_q  <= 1'b0;
      fwd_a_q   <= FWD_RF;
      fwd_b_q   <= FWD_RF;
      cnt_q     <= '0;
    end else begin
      ex_q      <= ex_d;
      mem_dst_q <= ex_q.dst;
      mem_wr_q  <= ex_q.reg_write;
      fwd_a_q   <= fwd_a_d;
      fwd_b_q   <= fwd_b_d;
      cnt_q     <= cnt_d;
    end
  end

  assign fwd_a     = fwd_a_q;
  assign fwd_b     = fwd_b_q;
  assign stall     = stall_c;
  assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Scoreboard bench for fwd_hazard_ctrl: a history-based reference model
// predicts stall, selects and stall count; a monitor process checks them.
module tb_fwd_hazard_ctrl;

  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             id_valid;
  logic [4:0]       id_rs, id_rt, id_dst;
  logic             id_reg_write, id_mem_read, flush;
  logic [1:0]       fwd_a, fwd_b;
  logic             stall;
  logic [CNT_W-1:0] stall_cnt;

  fwd_hazard_ctrl #(.REG_ADDR_W(5), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_valid     (id_valid),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_dst       (id_dst),
    .id_reg_write (id_reg_write),
    .id_mem_read  (id_mem_read),
    .flush        (flush),
    .fwd_a        (fwd_a),
    .fwd_b        (fwd_b),
    .stall        (stall),
    .stall_cnt    (stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] dst;
    bit         wr;
    bit         ld;
  } ins_t;

  typedef struct {
    bit stall;
    int fa;
    int fb;
    int cnt;
  } exp_t;

  // hist[0]: what entered EX one slot ago, hist[1]: two slots ago
  ins_t hist[2];
  int   mcnt;
  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  bit   done  = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    hist[0] = '{5'd0, 1'b0, 1'b0};
    hist[1] = '{5'd0, 1'b0, 1'b0};
    mcnt    = 0;
  endfunction

  // Most recent writer of s among the two in-flight instructions
  function automatic int fsel(input logic [4:0] s);
    if (s == 5'd0) return 0;
    if (hist[0].wr && hist[0].dst == s) return 1;
    if (hist[1].wr && hist[1].dst == s) return 2;
    return 0;
  endfunction

  task automatic issue(input bit v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] dst, input bit wr, input bit ld,
                       input bit fl, output bit acc);
    exp_t e;
    bit   st;
    @(negedge clk);
    id_valid = v; id_rs = rs; id_rt = rt; id_dst = dst;
    id_reg_write = wr; id_mem_read = ld; flush = fl;
    st  = v && !fl && hist[0].ld && hist[0].wr && hist[0].dst != 5'd0 &&
          (hist[0].dst == rs || hist[0].dst == rt);
    acc = v && !st && !fl;
    e.stall = st;
    e.fa    = acc ? fsel(rs) : 0;
    e.fb    = acc ? fsel(rt) : 0;
    if (st && mcnt != CNT_MAX) mcnt++;
    e.cnt   = mcnt;
    q.push_back(e);
    hist[1] = hist[0];
    hist[0] = acc ? '{dst, wr, ld} : '{5'd0, 1'b0, 1'b0};
  endtask

  // Re-present an instruction until the model says it was taken (or flushed)
  task automatic send(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] dst,
                      input bit wr, input bit ld, input bit fl);
    bit acc;
    int tries = 0;
    do begin
      issue(1'b1, rs, rt, dst, wr, ld, fl, acc);
      tries++;
    end while (!acc && !fl && tries < 4);
    if (!acc && !fl) check("send_bound", tries, 0);
  endtask

  task automatic drain();
    int n = 0;
    @(negedge clk);
    id_valid = 1'b0; flush = 1'b0;
    while (q.size() != 0 && n < 10) begin
      @(posedge clk); #2;
      n++;
    end
    @(posedge clk); #2;
    check("drain_bound", q.size(), 0);
  endtask

  task automatic rand_inputs();
    id_valid = 1'(($urandom & 1)); id_rs = 5'($urandom); id_rt = 5'($urandom);
    id_dst = 5'($urandom); id_reg_write = 1'($urandom); id_mem_read = 1'($urandom);
    flush = 1'($urandom);
  endtask

  // Monitor: stall checked mid-cycle, registered outputs just after the edge
  initial begin
    exp_t e;
    while (!done) begin
      @(negedge clk); #2;
      if (q.size() != 0) begin
        e = q.pop_front();
        check("stall", int'(stall), int'(e.stall));
        @(posedge clk); #1;
        check("fwd_a", int'(fwd_a), e.fa);
        check("fwd_b", int'(fwd_b), e.fb);
        check("stall_cnt", int'(stall_cnt), e.cnt);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    bit acc;
    rst_n = 1'b0;
    model_reset();
    rand_inputs();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      rand_inputs();
      #2;
      check("rst_fwd_a", int'(fwd_a), 0);
      check("rst_fwd_b", int'(fwd_b), 0);
      check("rst_stall", int'(stall), 0);
      check("rst_cnt", int'(stall_cnt), 0);
    end
    @(negedge clk);
    id_valid = 1'b0; flush = 1'b0;
    rst_n = 1'b1;

    // back-to-back ALU forwarding
    send(5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0);
    send(5'd3, 5'd3, 5'd4, 1'b1, 1'b0, 1'b0);
    // distance-2 forwarding
    send(5'd0, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0);
    send(5'd1, 5'd2, 5'd6, 1'b1, 1'b0, 1'b0);
    send(5'd5, 5'd0, 5'd9, 1'b1, 1'b0, 1'b0);
    // EX/MEM priority over MEM/WB
    send(5'd0, 5'd0, 5'd7, 1'b1, 1'b0, 1'b0);
    send(5'd0, 5'd0, 5'd7, 1'b1, 1'b0, 1'b0);
    send(5'd1, 5'd7, 5'd10, 1'b1, 1'b0, 1'b0);
    // load-use: one stall, then select from MEM/WB
    send(5'd0, 5'd0, 5'd8, 1'b1, 1'b1, 1'b0);
    send(5'd8, 5'd1, 5'd11, 1'b1, 1'b0, 1'b0);
    // writes to $0 never forward
    send(5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0);
    send(5'd0, 5'd0, 5'd12, 1'b1, 1'b0, 1'b0);
    // load-use with simultaneous flush
    send(5'd0, 5'd0, 5'd8, 1'b1, 1'b1, 1'b0);
    send(5'd8, 5'd8, 5'd13, 1'b1, 1'b0, 1'b1);
    send(5'd2, 5'd3, 5'd14, 1'b1, 1'b0, 1'b0);

    // random traffic
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        issue(1'b0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
              5'($urandom_range(0, 7)), 1'b1, 1'b0, 1'b0, acc);
      end else begin
        send(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
             1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0),
             1'($urandom_range(0, 9) == 0));
      end
    end

    // saturate the stall counter
    for (int i = 0; i < CNT_MAX + 2; i++) begin
      send(5'd0, 5'd0, 5'd8, 1'b1, 1'b1, 1'b0);
      send(5'd8, 5'd0, 5'd1, 1'b1, 1'b0, 1'b0);
    end

    // asynchronous reset while a load-use stall is pending
    send(5'd0, 5'd0, 5'd9, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    id_valid = 1'b1; id_rs = 5'd9; id_rt = 5'd0; id_dst = 5'd2;
    id_reg_write = 1'b1; id_mem_read = 1'b0; flush = 1'b0;
    #2;
    check("pre_rst_stall", int'(stall), 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_stall", int'(stall), 0);
    check("mid_rst_fwd_a", int'(fwd_a), 0);
    check("mid_rst_fwd_b", int'(fwd_b), 0);
    check("mid_rst_cnt", int'(stall_cnt), 0);
    model_reset();
    @(negedge clk);
    id_valid = 1'b0;
    rst_n = 1'b1;
    send(5'd0, 5'd0, 5'd6, 1'b1, 1'b1, 1'b0);
    send(5'd6, 5'd6, 5'd3, 1'b1, 1'b0, 1'b0);
    send(5'd3, 5'd6, 5'd4, 1'b1, 1'b0, 1'b0);

    drain();
    done = 1'b1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_ctrl.md
Name: fwd_hazard_ctrl

Overview:
- Forwarding and load-use hazard controller for the 5-stage MIPS pipeline.
- Produces the 2-bit select codes that drive the two 3-input operand muxes (ALU A and ALU B) in the EX stage.
- Tracks destination-register tags through the ID/EX, EX/MEM and MEM/WB stages.
- Raises a stall on load-use hazards, inserts bubbles, and counts stall cycles.

Parameters:
- REG_ADDR_W, 5, register-index width.
- CNT_W, 16, width of the stall-cycle counter.

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- id_valid  input  1  instruction in ID is valid.
- id_rs  input  REG_ADDR_W  source register A of the ID instruction.
- id_rt  input  REG_ADDR_W  source register B of the ID instruction.
- id_dst  input  REG_ADDR_W  destination register of the ID instruction.
- id_reg_write  input  1  ID instruction writes the register file.
- id_mem_read  input  1  ID instruction is a load.
- flush  input  1  squash the ID instruction (branch taken).
- fwd_a  output  2  EX operand-A mux select.
- fwd_b  output  2  EX operand-B mux select.
- stall  output  1  hold PC and IF/ID this cycle.
- stall_cnt  output  CNT_W  saturating count of stall cycles.

Behaviour:
- Select encoding: 0 = register-file value, 1 = EX/MEM result, 2 = MEM/WB result. The value 3 is never driven.
- Internal tag pipeline:
  - EX stage holds dst, reg_write, mem_read.
  - MEM stage holds dst, reg_write.
  - WB stage holds dst, reg_write.
  - MEM captures EX and WB captures MEM on every edge, with no hold.
- EX entry on each edge:
  - If id_valid & ~stall & ~flush, EX captures id_dst, id_reg_write and id_mem_read.
  - Otherwise EX captures a bubble (dst = 0, reg_write = 0, mem_read = 0).
- fwd_a / fwd_b are registered and computed from ID values on the same edge the instruction enters EX. For each source s (id_rs → fwd_a, id_rt → fwd_b):
  - If s == 0, select 0.
  - Else if EX.reg_write & EX.dst == s, select 1 (the producer moves to MEM).
  - Else if MEM.reg_write & MEM.dst == s, select 2 (the producer moves to WB).
  - Else select 0.
  - EX/MEM has priority over MEM/WB.
  - When a bubble enters EX, both selects are 0.
- WB-stage producers are not forwarded. The register file writes before it reads in the same cycle.
- stall is combinational:
  - stall = id_valid & ~flush & EX.mem_read & EX.reg_write & EX.dst != 0 & (EX.dst == id_rs | EX.dst == id_rt).
  - Exactly one stall cycle per load-use. On the next cycle the load is in MEM, so the held instruction receives select 2.
- stall_cnt increments on each edge where stall = 1 and saturates at all-ones.
- flush and hazard in the same cycle: flush wins. stall = 0, a bubble enters EX, and stall_cnt does not increment.
- Reset (asynchronous, any time, including mid-stall):
  - All stage tags, reg_write and mem_read bits cleared.
  - fwd_a = fwd_b = 0, stall_cnt = 0, stall = 0.
  - Operation resumes on the first edge after rst_n rises.

Decomposition:
- Shared package mips_pipe_pkg holds:
  - FWD_RF = 2'd0, FWD_MEM = 2'd1, FWD_WB = 2'd2.
  - REG_ZERO = 5'd0.
  - The tag-stage struct (dst, reg_write, mem_read).
- One natural sub-module, fwd_select: combinational compare of one source against the EX and MEM tags, returning a 2-bit select. Instantiated twice.

Test Plan:
- Reset: hold rst_n = 0 with random inputs → fwd_a = fwd_b = 0, stall = 0, stall_cnt = 0. Assert rst_n mid-stall → all clear immediately.
- Back-to-back ALU ops: add $3 (dst = 3, reg_write = 1), then sub reading rs = 3, rt = 3 → on its EX entry fwd_a = 1, fwd_b = 1, stall never asserted.
- Distance-2 forwarding: producer dst = 5, then an unrelated instruction, then a consumer with rs = 5 → fwd_a = 2.
- Priority: producers to $7 at distance 1 and 2, consumer rt = 7 → fwd_b = 1.
- Load-use: lw dst = 8 (mem_read = 1), then a consumer with rs = 8 →
  - stall = 1 for exactly one cycle and stall_cnt = 1.
  - A bubble enters EX with fwd = 0.
  - The next cycle the consumer enters EX with fwd_a = 2.
- Corner cases:
  - Destination $0 with a consumer rs = 0 → fwd_a = 0.
  - Load-use with flush = 1 the same cycle → stall = 0, stall_cnt unchanged.
  - Preload the counter to all-ones (CNT_W = 4) and trigger another stall → stall_cnt stays 15.
